// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard controller and its mult/div busy timer.
package stall_ctrl_pkg;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;
    typedef logic [4:0] reg_idx_t;

    localparam tuse_t TUSE_NONE       = 2'd3;
    localparam int    MD_MULT_CYCLES  = 5;
    localparam int    MD_DIV_CYCLES   = 10;
    localparam int    MD_CNT_W        = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A source operand stalls D when a younger-needed value is still in flight in E or M.
    function automatic logic reg_hazard(
        input reg_idx_t src,
        input tuse_t    tuse,
        input reg_idx_t a3_e,
        input tnew_t    tnew_e,
        input reg_idx_t a3_m,
        input tnew_t    tnew_m
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((src == a3_e) && (tuse < tnew_e)) ||
                ((src == a3_m) && (tuse < tnew_m)));
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// Countdown of the multi-cycle mult/div unit; busy while the loaded cycle count is non-zero.
module md_busy_timer
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // A start seen while counting can only follow a flush, so it simply restarts the count.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else if (start) begin
            state_q <= MD_BUSY;
            cnt_q   <= load_val;
        end else if (state_q == MD_BUSY) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_q <= MD_IDLE;
            end
        end
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: Tuse/Tnew data stalls, mult/div busy stalls, stall statistics.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = MD_CNT_W,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs_D,
    input  logic [4:0]        rt_D,
    input  logic [1:0]        tuse_rs,
    input  logic [1:0]        tuse_rt,
    input  logic [4:0]        a3_E,
    input  logic [1:0]        tnew_E,
    input  logic [4:0]        a3_M,
    input  logic [1:0]        tnew_M,
    input  logic              md_start_E,
    input  logic              md_is_div_E,
    input  logic              md_use_D,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_clr,
    output logic              md_busy,
    output logic [STAT_W-1:0] stall_cnt
);

    logic              stall_rs;
    logic              stall_rt;
    logic              stall_md;
    logic              stall;
    logic [STAT_W-1:0] stall_cnt_q;
    logic [STAT_W-1:0] stall_cnt_d;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_is_div_E),
        .busy   (md_busy)
    );

    assign stall_rs = reg_hazard(rs_D, tuse_rs, a3_E, tnew_E, a3_M, tnew_M);
    assign stall_rt = reg_hazard(rt_D, tuse_rt, a3_E, tnew_E, a3_M, tnew_M);
    // The start cycle itself must stall too: busy only rises after the load edge.
    assign stall_md = md_use_D & (md_busy | md_start_E);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign pc_en    = ~stall;
    assign ifid_en  = ~stall;
    assign idex_clr = stall;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
